universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//  WIDTH-bit universal shift register built as a chain of D-type storage stages.
//  Sits directly downstream of the D flip-flop cell and consumes its Q outputs.
//  Supports hold, shift right, shift left and parallel load, so one block covers
//  the SISO, SIPO, PISO and PIPO conversions.
//  Tracks the number of shifts since the last load and flags frame completion,
//  so serializer/deserializer users know when WIDTH bits have moved.
// PARAMETERS
//  WIDTH   4   register length in bits; legal for WIDTH >= 2
//  CNT_W   $clog2(WIDTH+1)   width of shift_cnt (derived, not overridden)
// PORTS
//  clk        in   1        rising-edge clock; the only clock
//  clr        in   1        reset, synchronous, active-high
//  en         in   1        clock enable; 0 = freeze all state
//  mode       in   2        00 hold, 01 shift right, 10 shift left, 11 parallel load
//  sin_r      in   1        serial input for right shift; enters q[WIDTH-1]
//  sin_l      in   1        serial input for left shift; enters q[0]
//  pin        in   WIDTH    parallel load data
//  q          out  WIDTH    register contents (parallel out)
//  qbar       out  WIDTH    bitwise complement of q
//  sout_r     out  1        serial out for right shift, = q[0]
//  sout_l     out  1        serial out for left shift, = q[WIDTH-1]
//  shift_cnt  out  CNT_W    shifts since last load/reset, saturates at WIDTH
//  frame_done out  1        one-cycle pulse on the shift that takes shift_cnt to WIDTH
// BEHAVIOUR
//  - q, shift_cnt and frame_done are registers; qbar, sout_r and sout_l are
//    combinational from q, with zero added latency.
//  - Reset: when clr=1 at a clk edge, q<=0, shift_cnt<=0 and frame_done<=0.
//    So qbar=all ones, sout_r=0 and sout_l=0.
//  - Reset priority: clr overrides en and mode.
//  - Reset mid-frame: a partial frame is discarded and no frame_done is produced.
//  - en=0 (clr=0): every register holds. frame_done<=0.
//  - en=1: one operation per edge, selected by mode.
//   - 00 hold: q and shift_cnt hold; frame_done<=0.
//   - 01 right: q<={sin_r, q[WIDTH-1:1]}.
//   - 10 left: q<={q[WIDTH-2:0], sin_l}.
//   - 11 load: q<=pin; shift_cnt<=0; frame_done<=0.
//  - Counter on a shift (mode 01 or 10):
//   - shift_cnt<=shift_cnt+1 if shift_cnt<WIDTH, else it holds (saturating, no wrap).
//   - frame_done<=1 only when shift_cnt==WIDTH-1 before the edge; otherwise 0.
//  - frame_done behaviour:
//   - It is high for exactly one cycle per frame.
//   - No re-pulse while shift_cnt is saturated.
//   - A load is required to re-arm it.
//  - Changing direction mid-frame is legal: both directions count toward the same frame.
//  - Serial outputs present the bit that leaves on the next edge:
//   - sout_r for right shifts; sout_l for left shifts.
//  - Output timing: all outputs are valid from the cycle after the causing edge.
//    There are no X states after the first reset.
//  - Inputs are sampled only at the rising edge of clk; there is no asynchronous path.
// TESTING (WIDTH=4)
//  1 Reset: clr=1,en=1,mode=11,pin=4'hF for 1 edge -> q=0000,qbar=1111,shift_cnt=0,frame_done=0.
//  2 PISO: load 1011, then 4x mode=01 with sin_r=0 -> sout_r before each shift = 1,1,0,1.
//    q goes 0101,0010,0001,0000; frame_done=1 only in the cycle after the 4th shift.
//  3 SIPO: after reset, 4x mode=10 with sin_l=1,0,0,1 -> q=1001, shift_cnt=4, one frame_done pulse.
//  4 Enable: load 0110, then en=0 with mode=01 for 3 edges -> q=0110, shift_cnt=0, frame_done=0.
//  5 Reset mid-frame: load 1111, 2 right shifts, then clr=1 -> q=0000, shift_cnt=0.
//    No frame_done pulse follows.
//  6 Saturation: load 1000, 6x mode=01 -> shift_cnt 1,2,3,4,4,4; frame_done pulses once.
//    Then load 0011 -> shift_cnt=0 and q=0011.

Source files
------------

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left / load) with
// a saturating shift counter and a one-cycle frame-complete pulse.
module universal_shift_reg #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sin_r,
   input  logic             sin_l,
   input  logic [WIDTH-1:0] pin,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             frame_done
);

   typedef enum logic [1:0] {
      M_HOLD  = 2'b00,
      M_RIGHT = 2'b01,
      M_LEFT  = 2'b10,
      M_LOAD  = 2'b11
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   mode_e            op;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             shift_req;

   assign op = mode_e'(mode);

   always_comb begin
      data_d    = data_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      shift_req = 1'b0;
      if (en) begin
         unique case (op)
            M_HOLD:  ;
            M_RIGHT: begin
               data_d    = {sin_r, data_q[WIDTH-1:1]};
               shift_req = 1'b1;
            end
            M_LEFT:  begin
               data_d    = {data_q[WIDTH-2:0], sin_l};
               shift_req = 1'b1;
            end
            M_LOAD:  begin
               data_d = pin;
               cnt_d  = '0;
            end
            default: ;
         endcase
      end
      // Counter saturates at WIDTH, so the pulse cannot recur until a load clears it.
      if (shift_req) begin
         if (cnt_q < CNT_MAX) cnt_d = cnt_q + 1'b1;
         done_d = (cnt_q == CNT_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         data_q <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign q          = data_q;
   assign qbar       = ~data_q;
   assign sout_r     = data_q[0];
   assign sout_l     = data_q[WIDTH-1];
   assign shift_cnt  = cnt_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed table-driven bench for universal_shift_reg at WIDTH=4, plus a
// hand-written sequence for enable gating around the frame boundary.
module tb_universal_shift_reg;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 3;

   logic          clk = 1'b0;
   logic          clr, en, sin_r, sin_l;
   logic [1:0]    mode;
   logic [W-1:0]  pin;
   logic [W-1:0]  q, qbar;
   logic          sout_r, sout_l, frame_done;
   logic [CW-1:0] shift_cnt;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   universal_shift_reg #(.WIDTH(W)) dut (
      .clk        (clk),
      .clr        (clr),
      .en         (en),
      .mode       (mode),
      .sin_r      (sin_r),
      .sin_l      (sin_l),
      .pin        (pin),
      .q          (q),
      .qbar       (qbar),
      .sout_r     (sout_r),
      .sout_l     (sout_l),
      .shift_cnt  (shift_cnt),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          clr;
      logic          en;
      logic [1:0]    mode;
      logic          sin_r;
      logic          sin_l;
      logic [W-1:0]  pin;
      logic [W-1:0]  eq;
      logic [CW-1:0] ecnt;
      logic          efd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic c, input logic e, input logic [1:0] m,
                               input logic sr, input logic sl, input logic [W-1:0] p,
                               input logic [W-1:0] eq, input logic [CW-1:0] ecnt,
                               input logic efd);
      vec_t v;
      v.clr = c; v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl; v.pin = p;
      v.eq = eq; v.ecnt = ecnt; v.efd = efd;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
   endtask

   task automatic check_outputs(input int idx, input logic [W-1:0] eq,
                                input logic [CW-1:0] ecnt, input logic efd);
      logic [W-1:0] eqb;
      eqb = ~eq;
      chk("q",          idx, 32'(q),          32'(eq));
      chk("qbar",       idx, 32'(qbar),       32'(eqb));
      chk("sout_r",     idx, 32'(sout_r),     32'(eq[0]));
      chk("sout_l",     idx, 32'(sout_l),     32'(eq[W-1]));
      chk("shift_cnt",  idx, 32'(shift_cnt),  32'(ecnt));
      chk("frame_done", idx, 32'(frame_done), 32'(efd));
   endtask

   task automatic step(input logic c, input logic e, input logic [1:0] m,
                       input logic sr, input logic sl, input logic [W-1:0] p);
      clr = c; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0; pin = '0;

      //            clr  en   mode   sr   sl   pin      q        cnt   fd
      // reset with conflicting load request
      vecs.push_back(mk(1, 1, 2'b11, 0, 0, 4'hF, 4'b0000, 3'd0, 0));
      // PISO: load 1011, four right shifts
      vecs.push_back(mk(0, 1, 2'b11, 0, 0, 4'hB, 4'b1011, 3'd0, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0101, 3'd1, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0010, 3'd2, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0001, 3'd3, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 3'd4, 1));
      vecs.push_back(mk(0, 1, 2'b00, 0, 0, 4'h0, 4'b0000, 3'd4, 0));
      // SIPO: reset then four left shifts 1,0,0,1, one extra at saturation
      vecs.push_back(mk(1, 0, 2'b00, 0, 0, 4'h0, 4'b0000, 3'd0, 0));
      vecs.push_back(mk(0, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 3'd1, 0));
      vecs.push_back(mk(0, 1, 2'b10, 0, 0, 4'h0, 4'b0010, 3'd2, 0));
      vecs.push_back(mk(0, 1, 2'b10, 0, 0, 4'h0, 4'b0100, 3'd3, 0));
      vecs.push_back(mk(0, 1, 2'b10, 0, 1, 4'h0, 4'b1001, 3'd4, 1));
      vecs.push_back(mk(0, 1, 2'b10, 0, 0, 4'h0, 4'b0010, 3'd4, 0));
      // enable low freezes everything
      vecs.push_back(mk(0, 1, 2'b11, 0, 0, 4'h6, 4'b0110, 3'd0, 0));
      vecs.push_back(mk(0, 0, 2'b01, 1, 1, 4'h0, 4'b0110, 3'd0, 0));
      vecs.push_back(mk(0, 0, 2'b01, 1, 1, 4'h0, 4'b0110, 3'd0, 0));
      vecs.push_back(mk(0, 0, 2'b11, 1, 1, 4'h9, 4'b0110, 3'd0, 0));
      // reset mid-frame discards the partial frame
      vecs.push_back(mk(0, 1, 2'b11, 0, 0, 4'hF, 4'b1111, 3'd0, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0111, 3'd1, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0011, 3'd2, 0));
      vecs.push_back(mk(1, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 3'd0, 0));
      vecs.push_back(mk(0, 1, 2'b00, 0, 0, 4'h0, 4'b0000, 3'd0, 0));
      vecs.push_back(mk(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 3'd1, 0));
      vecs.push_back(mk(0, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 3'd2, 0));
      // saturation: six right shifts, single pulse, load re-arms
      vecs.push_back(mk(0, 1, 2'b11, 0, 0, 4'h8, 4'b1000, 3'd0, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0100, 3'd1, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0010, 3'd2, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0001, 3'd3, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 3'd4, 1));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 3'd4, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 3'd4, 0));
      vecs.push_back(mk(0, 1, 2'b11, 0, 0, 4'h3, 4'b0011, 3'd0, 0));
      // mixed directions count toward one frame
      vecs.push_back(mk(0, 1, 2'b11, 0, 0, 4'h5, 4'b0101, 3'd0, 0));
      vecs.push_back(mk(0, 1, 2'b01, 1, 0, 4'h0, 4'b1010, 3'd1, 0));
      vecs.push_back(mk(0, 1, 2'b10, 0, 1, 4'h0, 4'b0101, 3'd2, 0));
      vecs.push_back(mk(0, 1, 2'b01, 0, 1, 4'h0, 4'b0010, 3'd3, 0));
      vecs.push_back(mk(0, 1, 2'b10, 1, 0, 4'h0, 4'b0100, 3'd4, 1));
      vecs.push_back(mk(0, 1, 2'b00, 1, 1, 4'hF, 4'b0100, 3'd4, 0));

      @(negedge clk);
      foreach (vecs[i]) begin
         step(vecs[i].clr, vecs[i].en, vecs[i].mode, vecs[i].sin_r, vecs[i].sin_l, vecs[i].pin);
         check_outputs(i, vecs[i].eq, vecs[i].ecnt, vecs[i].efd);
      end

      // enable gating at count WIDTH-1: pulse must wait for the real fourth shift
      step(0, 1, 2'b11, 0, 0, 4'hC); check_outputs(100, 4'b1100, 3'd0, 0);
      step(0, 1, 2'b10, 0, 1, 4'h0); check_outputs(101, 4'b1001, 3'd1, 0);
      step(0, 1, 2'b10, 0, 1, 4'h0); check_outputs(102, 4'b0011, 3'd2, 0);
      step(0, 1, 2'b10, 0, 0, 4'h0); check_outputs(103, 4'b0110, 3'd3, 0);
      step(0, 0, 2'b10, 0, 1, 4'h0); check_outputs(104, 4'b0110, 3'd3, 0);
      step(0, 0, 2'b01, 1, 1, 4'h0); check_outputs(105, 4'b0110, 3'd3, 0);
      step(0, 1, 2'b10, 0, 1, 4'h0); check_outputs(106, 4'b1101, 3'd4, 1);
      step(0, 0, 2'b10, 0, 1, 4'h0); check_outputs(107, 4'b1101, 3'd4, 0);
      step(0, 1, 2'b01, 0, 0, 4'h0); check_outputs(108, 4'b0110, 3'd4, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
